// File: rtl/rv32e_pkg.sv
// Shared RV32E register-file definitions: sizes, zero-register select and the
// debug sequencer state encoding used by regfile_access_ctrl.
package rv32e_pkg;

    localparam int NUM_REGS = 16;
    localparam int XLEN     = 32;
    localparam int SEL_W    = 4;

    localparam logic [SEL_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        DBG_WR,
        DBG_RD,
        DONE,
        WAIT
    } dbg_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Load scoreboard: one pending bit per architectural register, set by load
// issue and cleared by load writeback. x0 can never become pending.
import rv32e_pkg::*;

module reg_scoreboard (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [SEL_W-1:0]    i_set_sel,
    input  logic                i_clr_en,
    input  logic [SEL_W-1:0]    i_clr_sel,
    input  logic [SEL_W-1:0]    i_lk_sel_a,
    input  logic [SEL_W-1:0]    i_lk_sel_b,
    output logic                o_hit_a,
    output logic                o_hit_b,
    output logic [NUM_REGS-1:0] o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Decode set/clear requests into one-hot masks; select 0 is dropped
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_sel != REG_ZERO)) w_set_mask[i_set_sel] = 1'b1;
        if (i_clr_en && (i_clr_sel != REG_ZERO)) w_clr_mask[i_clr_sel] = 1'b1;
    end

    // Clear first, then set, so a same-edge set on the same register wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign o_hit_a   = r_pending[i_lk_sel_a];
    assign o_hit_b   = r_pending[i_lk_sel_b];
    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Write-port sequencer/arbiter for the RV32E 16x32 register file.
// Shares the single write port between execute writeback, load writeback and
// (with REGFILE_DEBUG_EN defined) a debug port that also borrows read port 2.
// Keeps a load scoreboard and reports read hazards to decode.
import rv32e_pkg::*;

module regfile_access_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ex_wr_valid,
    output logic             o_ex_wr_ready,
    input  logic [SEL_W-1:0] i_ex_wr_sel,
    input  logic [XLEN-1:0]  i_ex_wr_data,
    input  logic             i_ld_issue_valid,
    output logic             o_ld_issue_ready,
    input  logic [SEL_W-1:0] i_ld_issue_sel,
    input  logic             i_ld_wr_valid,
    output logic             o_ld_wr_ready,
    input  logic [SEL_W-1:0] i_ld_wr_sel,
    input  logic [XLEN-1:0]  i_ld_wr_data,
    input  logic [SEL_W-1:0] i_rd_sel1,
    input  logic [SEL_W-1:0] i_rd_sel2,
    output logic             o_rd_hazard,
    output logic [SEL_W-1:0] o_rf_write_register,
    output logic [XLEN-1:0]  o_rf_write_value,
    output logic [SEL_W-1:0] o_rf_r_sel2,
    input  logic [XLEN-1:0]  i_rf_r_value2,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [SEL_W-1:0] i_dbg_sel,
    input  logic [XLEN-1:0]  i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [XLEN-1:0]  o_dbg_rdata
);

    logic [SEL_W-1:0]    r_wr_sel;
    logic [XLEN-1:0]     r_wr_data;
    logic                r_last_ld;
    logic                w_dbg_wr_busy;
    logic                w_ex_pend;
    logic                w_li_pend;
    logic                w_ex_elig;
    logic                w_ex_fire;
    logic                w_ld_fire;
    logic                w_li_fire;
    logic [NUM_REGS-1:0] w_pending;
    logic [SEL_W-1:0]    w_gnt_sel;
    logic [XLEN-1:0]     w_gnt_data;
    logic                w_haz1;
    logic                w_haz2;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_li_fire),
        .i_set_sel  (i_ld_issue_sel),
        .i_clr_en   (w_ld_fire),
        .i_clr_sel  (i_ld_wr_sel),
        .i_lk_sel_a (i_ex_wr_sel),
        .i_lk_sel_b (i_ld_issue_sel),
        .o_hit_a    (w_ex_pend),
        .o_hit_b    (w_li_pend),
        .o_pending  (w_pending)
    );

    // An execute write to a register with a load outstanding would be
    // overwritten out of order, so it is held off (WAW) and does not take part
    // in round-robin; ld then wins alone and can retire the pending load.
    assign w_ex_elig        = i_ex_wr_valid && !w_ex_pend;
    assign o_ex_wr_ready    = !w_dbg_wr_busy && !w_ex_pend && !(i_ld_wr_valid && !r_last_ld);
    assign o_ld_wr_ready    = !w_dbg_wr_busy && !(w_ex_elig && r_last_ld);
    assign o_ld_issue_ready = !w_li_pend;

    assign w_ex_fire = i_ex_wr_valid && o_ex_wr_ready;
    assign w_ld_fire = i_ld_wr_valid && o_ld_wr_ready;
    assign w_li_fire = i_ld_issue_valid && o_ld_issue_ready;

    // Select the single write for this cycle; debug write has top priority
    always_comb begin
        w_gnt_sel  = REG_ZERO;
        w_gnt_data = '0;
        if (w_dbg_wr_busy) begin
            w_gnt_sel  = i_dbg_sel;
            w_gnt_data = i_dbg_wdata;
        end else if (w_ex_fire) begin
            w_gnt_sel  = i_ex_wr_sel;
            w_gnt_data = i_ex_wr_data;
        end else if (w_ld_fire) begin
            w_gnt_sel  = i_ld_wr_sel;
            w_gnt_data = i_ld_wr_data;
        end
    end

    // Write stage: holds the granted write for one cycle, empty when no grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel  <= REG_ZERO;
            r_wr_data <= '0;
            r_last_ld <= 1'b0;
        end else begin
            r_wr_sel  <= w_gnt_sel;
            r_wr_data <= (w_gnt_sel == REG_ZERO) ? '0 : w_gnt_data;
            if (w_ex_fire || w_ld_fire) r_last_ld <= w_ld_fire;
        end
    end

    assign o_rf_write_register = r_wr_sel;
    assign o_rf_write_value    = r_wr_data;

    // A source is hazardous while its load is outstanding or while it sits in
    // the write stage (the file has not been updated yet)
    assign w_haz1 = (i_rd_sel1 != REG_ZERO) && (w_pending[i_rd_sel1] || (r_wr_sel == i_rd_sel1));
    assign w_haz2 = (i_rd_sel2 != REG_ZERO) && (w_pending[i_rd_sel2] || (r_wr_sel == i_rd_sel2));
    assign o_rd_hazard = w_haz1 || w_haz2;

`ifdef REGFILE_DEBUG_EN
    dbg_state_t      r_dbg_state;
    logic            r_dbg_ack;
    logic [XLEN-1:0] r_dbg_rdata;

    // Debug sequencer: one write or read per request, ack pulse, then wait
    // for the requester to drop dbg_req before accepting another
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbg_state <= IDLE;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_dbg_ack <= 1'b0;
            case (r_dbg_state)
                IDLE: if (i_dbg_req) r_dbg_state <= i_dbg_we ? DBG_WR : DBG_RD;
                DBG_WR: begin
                    r_dbg_state <= DONE;
                    r_dbg_ack   <= 1'b1;
                end
                DBG_RD: begin
                    r_dbg_rdata <= i_rf_r_value2;
                    r_dbg_state <= DONE;
                    r_dbg_ack   <= 1'b1;
                end
                DONE:    r_dbg_state <= WAIT;
                WAIT:    if (!i_dbg_req) r_dbg_state <= IDLE;
                default: r_dbg_state <= IDLE;
            endcase
        end
    end

    assign w_dbg_wr_busy = (r_dbg_state == DBG_WR);
    assign o_rf_r_sel2   = (r_dbg_state == DBG_RD) ? i_dbg_sel : i_rd_sel2;
    assign o_dbg_ack     = r_dbg_ack;
    assign o_dbg_rdata   = r_dbg_rdata;
`else
    logic w_unused;
    assign w_unused      = ^{i_dbg_req, i_dbg_we, i_dbg_sel, i_dbg_wdata, i_rf_r_value2};
    assign w_dbg_wr_busy = 1'b0;
    assign o_rf_r_sel2   = i_rd_sel2;
    assign o_dbg_ack     = 1'b0;
    assign o_dbg_rdata   = '0;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed vector table, randomized run against
// a behavioural scoreboard/arbiter model, debug sequences when enabled.
module tb_regfile_access_ctrl;
    import rv32e_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ex_v, ex_r, li_v, li_r, lw_v, lw_r, haz, dbg_req, dbg_we, dbg_ack;
    logic [3:0]  ex_s, li_s, lw_s, rs1, rs2, wreg, rsel2, dbg_sel;
    logic [31:0] ex_d, lw_d, wval, rval2, dbg_wdata, dbg_rdata;

    logic [31:0] rf_mem [16];

    regfile_access_ctrl dut (
        .clk(clk), .rst(rst),
        .i_ex_wr_valid(ex_v), .o_ex_wr_ready(ex_r), .i_ex_wr_sel(ex_s), .i_ex_wr_data(ex_d),
        .i_ld_issue_valid(li_v), .o_ld_issue_ready(li_r), .i_ld_issue_sel(li_s),
        .i_ld_wr_valid(lw_v), .o_ld_wr_ready(lw_r), .i_ld_wr_sel(lw_s), .i_ld_wr_data(lw_d),
        .i_rd_sel1(rs1), .i_rd_sel2(rs2), .o_rd_hazard(haz),
        .o_rf_write_register(wreg), .o_rf_write_value(wval),
        .o_rf_r_sel2(rsel2), .i_rf_r_value2(rval2),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_sel(dbg_sel), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata)
    );

    // Register file behind the controller
    always @(posedge clk) if (wreg != 4'd0) rf_mem[wreg] <= wval;
    assign rval2 = (rsel2 == 4'd0) ? 32'd0 : rf_mem[rsel2];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic exv; logic [3:0] exs; logic [31:0] exd;
        logic liv; logic [3:0] lis;
        logic lwv; logic [3:0] lws; logic [31:0] lwd;
        logic [3:0] rs1, rs2;
        logic e_exr, e_lir, e_lwr, e_haz;
        logic [3:0] e_wreg; logic [31:0] e_wval;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic exv, logic [3:0] exs, logic [31:0] exd,
                                logic liv, logic [3:0] lis,
                                logic lwv, logic [3:0] lws, logic [31:0] lwd,
                                logic [3:0] s1, logic [3:0] s2,
                                logic exr, logic lir, logic lwr, logic hz,
                                logic [3:0] wr, logic [31:0] wv);
        vec_t v;
        v.exv = exv; v.exs = exs; v.exd = exd; v.liv = liv; v.lis = lis;
        v.lwv = lwv; v.lws = lws; v.lwd = lwd; v.rs1 = s1; v.rs2 = s2;
        v.e_exr = exr; v.e_lir = lir; v.e_lwr = lwr; v.e_haz = hz;
        v.e_wreg = wr; v.e_wval = wv;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_v = 0; ex_s = 0; ex_d = 0; li_v = 0; li_s = 0;
        lw_v = 0; lw_s = 0; lw_d = 0; rs1 = 0; rs2 = 0;
        dbg_req = 0; dbg_we = 0; dbg_sel = 0; dbg_wdata = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Behavioural model state
    bit          m_pend [16];
    bit          m_last_ld;
    logic [3:0]  m_wsel;
    logic [31:0] m_wdata;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_last_ld = 0; m_wsel = 0; m_wdata = 0;
    endtask

    initial begin
        logic e_exr, e_lir, e_lwr, e_haz, exf, ldf, lif;
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'd0;
        rst = 1'b1;
        idle_inputs();

        // exv exs exd  liv lis  lwv lws lwd  rs1 rs2 | exr lir lwr haz wreg wval
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            0,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(1,5,32'hDEADBEEF,0,0, 0,0,0,            5,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            5,0, 1,1,1,1, 5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            5,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(1,3,32'h33,      0,0, 1,4,32'h44,       0,0, 0,1,1,0, 0,0));
        tbl.push_back(mk(1,3,32'h33,      0,0, 1,4,32'h44,       0,0, 1,1,0,0, 4,32'h44));
        tbl.push_back(mk(1,3,32'h33,      0,0, 1,4,32'h44,       0,0, 0,1,1,0, 3,32'h33));
        tbl.push_back(mk(1,3,32'h33,      0,0, 1,4,32'h44,       0,0, 1,1,0,0, 4,32'h44));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            0,0, 1,1,1,0, 3,32'h33));
        tbl.push_back(mk(0,0,0,           1,7, 0,0,0,            0,7, 1,1,1,0, 0,0));
        tbl.push_back(mk(1,7,32'h1,       1,7, 0,0,0,            0,7, 0,0,1,1, 0,0));
        tbl.push_back(mk(1,7,32'h1,       0,0, 1,7,32'h12345678, 0,7, 0,1,1,1, 0,0));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            0,7, 1,1,1,1, 7,32'h12345678));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            0,7, 1,1,1,0, 0,0));
        tbl.push_back(mk(1,0,32'hFFFFFFFF,0,0, 1,0,32'hFFFFFFFF, 0,0, 1,1,0,0, 0,0));
        tbl.push_back(mk(1,0,32'hFFFFFFFF,0,0, 1,0,32'hFFFFFFFF, 0,0, 0,1,1,0, 0,0));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            0,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(0,0,0,           1,9, 1,9,32'h99,       0,0, 1,1,1,0, 0,0));
        tbl.push_back(mk(0,0,0,           1,9, 0,0,0,            9,0, 1,0,1,1, 9,32'h99));
        tbl.push_back(mk(0,0,0,           0,0, 1,9,32'h999,      9,0, 1,1,1,1, 0,0));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            9,0, 1,1,1,1, 9,32'h999));
        tbl.push_back(mk(0,0,0,           0,0, 0,0,0,            9,0, 1,1,1,0, 0,0));

        reset_dut();
        foreach (tbl[k]) begin
            @(negedge clk);
            ex_v = tbl[k].exv; ex_s = tbl[k].exs; ex_d = tbl[k].exd;
            li_v = tbl[k].liv; li_s = tbl[k].lis;
            lw_v = tbl[k].lwv; lw_s = tbl[k].lws; lw_d = tbl[k].lwd;
            rs1 = tbl[k].rs1; rs2 = tbl[k].rs2;
            #1;
            chk($sformatf("row%0d ex_ready", k), ex_r, tbl[k].e_exr);
            chk($sformatf("row%0d ld_issue_ready", k), li_r, tbl[k].e_lir);
            chk($sformatf("row%0d ld_wr_ready", k), lw_r, tbl[k].e_lwr);
            chk($sformatf("row%0d rd_hazard", k), haz, tbl[k].e_haz);
            chk($sformatf("row%0d wr_reg", k), wreg, tbl[k].e_wreg);
            chk($sformatf("row%0d wr_val", k), wval, tbl[k].e_wval);
            chk($sformatf("row%0d r_sel2", k), rsel2, tbl[k].rs2);
            chk($sformatf("row%0d dbg_ack", k), dbg_ack, 0);
        end
        chk("dbg_rdata_idle", dbg_rdata, 0);

`ifdef REGFILE_DEBUG_EN
        // Debug write x2 colliding with an execute writeback
        reset_dut();
        @(negedge clk);
        dbg_req = 1; dbg_we = 1; dbg_sel = 2; dbg_wdata = 32'hA5A5A5A5;
        #1 chk("dbg_req_cycle_ack", dbg_ack, 0);
        @(negedge clk);
        ex_v = 1; ex_s = 6; ex_d = 32'h66;
        #1 chk("dbgwr_ex_ready", ex_r, 0);
        chk("dbgwr_ld_ready", lw_r, 0);
        chk("dbgwr_ack_early", dbg_ack, 0);
        @(negedge clk);
        #1 chk("dbgwr_ex_ready_back", ex_r, 1);
        chk("dbgwr_ack", dbg_ack, 1);
        chk("dbgwr_wreg", wreg, 2);
        chk("dbgwr_wval", wval, 32'hA5A5A5A5);
        @(negedge clk);
        ex_v = 0; dbg_req = 0;
        #1 chk("dbgwr_ack_pulse", dbg_ack, 0);
        chk("dbgwr_ex_wreg", wreg, 6);
        // Debug read x2 through read port 2
        @(negedge clk);
        rs2 = 5; dbg_req = 1; dbg_we = 0; dbg_sel = 2;
        #1 chk("dbgrd_idle_sel2", rsel2, 5);
        @(negedge clk);
        #1 chk("dbgrd_sel2", rsel2, 2);
        chk("dbgrd_ack_early", dbg_ack, 0);
        @(negedge clk);
        #1 chk("dbgrd_ack", dbg_ack, 1);
        chk("dbgrd_rdata", dbg_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        dbg_req = 0;
        #1 chk("dbgrd_ack_pulse", dbg_ack, 0);
        chk("dbgrd_sel2_back", rsel2, 5);
        // Reset in the middle of a debug read
        @(negedge clk);
        dbg_req = 1; dbg_we = 0; dbg_sel = 2;
        @(negedge clk);
        #1 chk("dbgrst_in_rd", rsel2, 2);
        rst = 1; dbg_req = 0;
        #1 chk("dbgrst_sel2", rsel2, 5);
        chk("dbgrst_rdata", dbg_rdata, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("dbgrst_ack", dbg_ack, 0);
            chk("dbgrst_sel2_idle", rsel2, 5);
        end
        dbg_sel = 0;
`endif

        // Randomized run against the behavioural model
        reset_dut();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ex_v = 1'($urandom_range(0, 1)); ex_s = 4'($urandom_range(0, 6)); ex_d = $urandom;
            li_v = 1'($urandom_range(0, 1)); li_s = 4'($urandom_range(0, 6));
            lw_v = 1'($urandom_range(0, 1)); lw_s = 4'($urandom_range(0, 6)); lw_d = $urandom;
            rs1 = 4'($urandom_range(0, 15)); rs2 = 4'($urandom_range(0, 7));
            #1;
            // ex may write unless a load to its target is outstanding or ld
            // is contending and ex had the previous turn; ld may write unless
            // an eligible ex is contending and ld had the previous turn.
            e_exr = !m_pend[ex_s] && !(lw_v && !m_last_ld);
            e_lwr = !((ex_v && !m_pend[ex_s]) && m_last_ld);
            e_lir = !m_pend[li_s];
            e_haz = (rs1 != 0 && (m_pend[rs1] || rs1 == m_wsel)) ||
                    (rs2 != 0 && (m_pend[rs2] || rs2 == m_wsel));
            chk("rnd ex_ready", ex_r, e_exr);
            chk("rnd ld_wr_ready", lw_r, e_lwr);
            chk("rnd ld_issue_ready", li_r, e_lir);
            chk("rnd rd_hazard", haz, e_haz);
            chk("rnd wr_reg", wreg, m_wsel);
            chk("rnd wr_val", wval, m_wdata);
            chk("rnd r_sel2", rsel2, rs2);
            exf = ex_v && e_exr;
            ldf = lw_v && e_lwr;
            lif = li_v && e_lir;
            if (exf)      begin m_wsel = ex_s; m_wdata = (ex_s == 0) ? 0 : ex_d; end
            else if (ldf) begin m_wsel = lw_s; m_wdata = (lw_s == 0) ? 0 : lw_d; end
            else          begin m_wsel = 0;    m_wdata = 0; end
            if (ldf && lw_s != 0) m_pend[lw_s] = 0;
            if (lif && li_s != 0) m_pend[li_s] = 1;
            if (exf || ldf) m_last_ld = ldf;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
